// File: rtl/dtree_seq_eval.sv
// Programmable sequential decision-tree classifier: walks a config-written node table
// from the root, one node per cycle, and reports the leaf class (or an error) on a valid/ready port.
module dtree_seq_eval #(
    parameter int N_FEAT    = 6,
    parameter int FEAT_W    = 8,
    parameter int N_NODES   = 64,
    parameter int CLASS_W   = 2,
    parameter int MAX_DEPTH = 16,
    parameter int NA_W      = $clog2(N_NODES),
    parameter int FI_W      = $clog2(N_FEAT),
    parameter int PR_W      = $clog2(FEAT_W + 1),
    parameter int NODE_W    = 1 + FI_W + PR_W + FEAT_W + 2 * NA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [NA_W-1:0]          cfg_addr,
    input  logic [NODE_W-1:0]        cfg_wdata,
    output logic                     cfg_ready,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err
);

    localparam int DP_W = $clog2(MAX_DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready/cfg_ready are high only in IDLE, out_valid only in DONE, and DONE holds its
    // outputs until out_ready is seen.
    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [NODE_W-1:0]   tbl_q [N_NODES];
    logic [NODE_W-1:0]   tbl_d [N_NODES];
    logic [FEAT_W-1:0]   x_q [N_FEAT];
    logic [FEAT_W-1:0]   x_d [N_FEAT];
    logic [NA_W-1:0]     ptr_q, ptr_d;
    logic [DP_W-1:0]     depth_q, depth_d;
    logic [CLASS_W-1:0]  class_q, class_d;
    logic                err_q, err_d;

    logic [NODE_W-1:0]   node;
    logic                n_leaf;
    logic [FI_W-1:0]     n_feat;
    logic [PR_W-1:0]     n_prec;
    logic [FEAT_W-1:0]   n_thr;
    logic [NA_W-1:0]     n_left;
    logic [NA_W-1:0]     n_right;
    logic [FEAT_W-1:0]   feat_val;
    logic                feat_bad;
    logic [PR_W-1:0]     p_eff;
    logic [PR_W-1:0]     shamt;
    logic [FEAT_W-1:0]   v;
    logic                go_left;

    always_comb begin
        node     = (int'(ptr_q) < N_NODES) ? tbl_q[ptr_q] : '0;
        n_leaf   = node[NODE_W-1];
        n_feat   = node[NODE_W-2 -: FI_W];
        n_prec   = node[NODE_W-2-FI_W -: PR_W];
        n_thr    = node[2*NA_W +: FEAT_W];
        n_left   = node[NA_W +: NA_W];
        n_right  = node[0 +: NA_W];
        feat_bad = int'(n_feat) >= N_FEAT;
        feat_val = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            if (n_feat == FI_W'(k)) feat_val = x_q[k];
        end
        // Keep only the p MSBs; p = 0 shifts everything out so the test always goes left.
        p_eff   = (int'(n_prec) > FEAT_W) ? PR_W'(FEAT_W) : n_prec;
        shamt   = PR_W'(FEAT_W) - p_eff;
        v       = feat_val >> shamt;
        go_left = v <= n_thr;
    end

    always_comb begin
        state_d = state_q;
        tbl_d   = tbl_q;
        x_d     = x_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we && int'(cfg_addr) < N_NODES) tbl_d[cfg_addr] = cfg_wdata;
                if (in_valid) begin
                    for (int k = 0; k < N_FEAT; k++) x_d[k] = in_x[k*FEAT_W +: FEAT_W];
                    ptr_d   = '0;
                    depth_d = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (n_leaf) begin
                    class_d = node[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (feat_bad || int'(depth_q) == MAX_DEPTH - 1) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ptr_d   = go_left ? n_left : n_right;
                    depth_d = depth_q + DP_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_NODES; i++) tbl_q[i] <= '0;
            for (int k = 0; k < N_FEAT; k++) x_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
            tbl_q   <= tbl_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign cfg_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_class = class_q;
    assign out_err   = err_q;

endmodule
